// File: rtl/check_sched_pkg.sv
// Shared types and defaults for the check-window scheduler.
package check_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CHECK,
        DRAIN,
        DONE
    } state_t;

    localparam int REQ_N_DEF  = 4;
    localparam int WIN_W_DEF  = 8;
    localparam int STAT_W_DEF = 16;

    // A zero-length window still gets one CHECK cycle.
    function automatic int unsigned win_clamp(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, one-hot plus index.
// Combinational, zero latency; no backpressure (pure function of inputs).
// Caller holds the grant stable by only sampling it while idle.
module rr_arbiter #(
    parameter int REQ_N = 4,
    parameter int PTR_W = 2
) (
    input  logic [REQ_N-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [REQ_N-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = (int'(ptr) + k) % REQ_N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/check_window_sched.sv
// Shares one property checker among REQ_N requesters; ARM/CHECK/DRAIN window per grant (WINDOW_STATS_EN adds pass counters).
// Latency: grant 1 cycle after request in IDLE, done win_len+3 cycles after request.
// Backpressure: requesters hold req_in until their done_out pulse; others wait in round-robin order.
module check_window_sched
    import check_sched_pkg::*;
#(
    parameter int REQ_N = REQ_N_DEF,
    parameter int WIN_W = WIN_W_DEF
`ifdef WINDOW_STATS_EN
    ,
    parameter int STAT_W = STAT_W_DEF
`endif
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [REQ_N-1:0]       req_in,
    input  logic [REQ_N*WIN_W-1:0] win_len_in,
    input  logic                   abort_in,
    input  logic                   chk_success_in,
    output logic                   check_sig_out,
    output logic                   disable_sig_out,
    output logic [REQ_N-1:0]       grant_out,
    output logic [REQ_N-1:0]       done_out,
    output logic                   pass_out,
    output logic                   aborted_out,
    output logic                   busy_out
`ifdef WINDOW_STATS_EN
    ,
    output logic [REQ_N*STAT_W-1:0] stat_out
`endif
);

    localparam int PTR_W = $clog2(REQ_N);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [WIN_W-1:0] win_cnt;
    logic             fail_flag;
    logic             abort_flag;
    logic [REQ_N-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic [WIN_W-1:0] win_sel;
    logic             abort_now;

    rr_arbiter #(
        .REQ_N (REQ_N),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req_in),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign win_sel   = win_len_in[int'(arb_idx)*WIN_W +: WIN_W];
    // The owner letting go of its request mid-window is handled like an explicit abort.
    assign abort_now = abort_in || !req_in[owner];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            win_cnt         <= '0;
            fail_flag       <= 1'b0;
            abort_flag      <= 1'b0;
            check_sig_out   <= 1'b0;
            disable_sig_out <= 1'b1;
            grant_out       <= '0;
            done_out        <= '0;
            pass_out        <= 1'b0;
            aborted_out     <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            done_out <= '0;
            case (state)
                IDLE: begin
                    if (|req_in) begin
                        state      <= ARM;
                        owner      <= arb_idx;
                        win_cnt    <= WIN_W'(win_clamp(32'(win_sel)));
                        grant_out  <= arb_gnt;
                        busy_out   <= 1'b1;
                        abort_flag <= 1'b0;
                    end
                end
                ARM: begin
                    fail_flag <= 1'b0;
                    if (abort_now) begin
                        state      <= DRAIN;
                        abort_flag <= 1'b1;
                    end else begin
                        state           <= CHECK;
                        check_sig_out   <= 1'b1;
                        disable_sig_out <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!chk_success_in) begin
                        fail_flag <= 1'b1;
                    end
                    if (abort_now || win_cnt == WIN_W'(1)) begin
                        state           <= DRAIN;
                        abort_flag      <= abort_now;
                        check_sig_out   <= 1'b0;
                        disable_sig_out <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    done_out    <= grant_out;
                    pass_out    <= !fail_flag && !abort_flag;
                    aborted_out <= abort_flag;
                end
                DONE: begin
                    state       <= IDLE;
                    grant_out   <= '0;
                    busy_out    <= 1'b0;
                    pass_out    <= 1'b0;
                    aborted_out <= 1'b0;
                    rr_ptr      <= (int'(owner) == REQ_N - 1) ? '0 : owner + PTR_W'(1);
                end
                default: begin
                    state           <= IDLE;
                    check_sig_out   <= 1'b0;
                    disable_sig_out <= 1'b1;
                    grant_out       <= '0;
                    busy_out        <= 1'b0;
                end
            endcase
        end
    end

`ifdef WINDOW_STATS_EN
    logic [STAT_W-1:0] stat_cnt [REQ_N];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REQ_N; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (state == DONE && pass_out && stat_cnt[owner] != '1) begin
            stat_cnt[owner] <= stat_cnt[owner] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < REQ_N; g++) begin : g_stat
        assign stat_out[g*STAT_W +: STAT_W] = stat_cnt[g];
    end
`endif

endmodule
